regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the memory-load path and the ALU result path.
- Keeps a per-register busy scoreboard for outstanding loads. Issue stalls on RAW and WAW hazards against pending loads.
- Sits between the execute/memory stages and the 16x16 register file. Register 0 is hardwired zero, and the block never writes it.

Parameters:
- NREGS, 16, number of architectural registers (index width = 4).
- XLEN, 16, data width.
- MAX_MEM_STREAK, 3, consecutive memory grants allowed while the ALU waits before the ALU is forced a grant.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_issue_valid  in  1  a load targeting ld_issue_idx is issued this cycle.
- ld_issue_idx  in  4  destination register of the issued load.
- ld_issue_ready  out  1  load issue accepted (combinational).
- mem_wb_valid  in  1  load data available.
- mem_wb_idx  in  4  load destination.
- mem_wb_data  in  16  load data.
- mem_wb_ready  out  1  load writeback accepted this cycle.
- alu_wb_valid  in  1  ALU result available.
- alu_wb_idx  in  4  ALU destination.
- alu_wb_data  in  16  ALU result.
- alu_wb_ready  out  1  ALU writeback accepted this cycle.
- hz_rs1_i  in  4  source register 1 of the instruction in decode.
- hz_rs2_i  in  4  source register 2 of the instruction in decode.
- hz_stall  out  1  decode must stall (combinational).
- rf_we  out  1  register-file write enable (registered).
- rf_idx  out  4  register-file write index (registered).
- rf_data  out  16  register-file write data (registered).
- busy_mask  out  16  scoreboard; bit i set means a load to ri is outstanding.

Behaviour:
- Reset (synchronous, active-high, single clock clk): rf_we=0, rf_idx=0, rf_data=0, busy_mask=0, streak counter=0. Reset mid-transfer discards any accepted-but-unwritten writeback, and all outstanding loads are forgotten.
- Handshakes: a transfer completes when valid && ready in the same cycle. Any ready output may depend combinationally on inputs. No output depends on a ready input.
- ld_issue_ready = !busy[ld_issue_idx] || ld_issue_idx==0. This blocks a second outstanding load to the same register.
- Issue to r0 is accepted but never sets a bit; busy_mask[0] is always 0.
- ALU WAW guard: the ALU is eligible only if alu_wb_idx==0 or !busy[alu_wb_idx].
- Arbitration (one grant per cycle):
  - If only one eligible requester is valid, it wins.
  - If both are valid and eligible, memory wins unless the streak counter equals MAX_MEM_STREAK; then the ALU wins.
- Streak counter:
  - Increments on each memory grant made while the ALU is valid and eligible, saturating at MAX_MEM_STREAK.
  - Clears on any ALU grant.
  - Clears on any cycle the ALU is not valid.
- mem_wb_ready = memory granted. alu_wb_ready = ALU granted.
- Write latency: 1 cycle.
  - On the granting edge, rf_we<=1 if the granted idx!=0, else 0.
  - rf_idx and rf_data are loaded from the winner on that edge.
  - With no grant, rf_we<=0 and rf_idx/rf_data hold.
  - The register file commits on the following edge.
- Scoreboard:
  - Bit set on the edge of an accepted ld_issue.
  - Bit cleared on the edge of a mem_wb handshake for that idx.
  - Same-edge set and clear of the same idx: set wins. Clear applies first, then set.
- mem_wb to a register whose bit is not set is still accepted and written. The bit stays 0.
- hz_stall = hit(hz_rs1_i) || hit(hz_rs2_i), where hit(r) = r!=0 && (busy[r] || (rf_we && rf_idx==r)).
  - The in-flight write term covers the one cycle where the busy bit has cleared but the register file is not yet updated.
- Simultaneous mem_wb and ld_issue to the same idx, with the bit set:
  - ld_issue_ready=0 that cycle because the bit is still set.
  - Issue succeeds on a later cycle.

Test Plan:
- Reset, then ALU writes r3=0x1234 alone → alu_wb_ready=1 the same cycle. Next cycle rf_we=1, rf_idx=3, rf_data=0x1234. The cycle after, rf_we=0.
- Issue load to r5, then query hz_rs1_i=5 → busy_mask=0x0020 and hz_stall=1. mem_wb r5=0xBEEF → bit clears and hz_stall stays 1 for the rf_we cycle. The following cycle hz_stall=0.
- Memory and ALU both valid for 6 cycles, ALU always eligible, MAX_MEM_STREAK=3 → grant order mem,mem,mem,alu; ALU accepted exactly on the 4th cycle.
- Load outstanding to r7, ALU wb to r7 valid → alu_wb_ready=0 until the mem r7 writeback commits. The ALU write lands after the load data: final rf_data=ALU value.
- ALU wb to r0 with data 0xFFFF → alu_wb_ready=1 and rf_we stays 0. Issue load to r0 → ld_issue_ready=1 and busy_mask stays 0.
- Load to r2 outstanding, assert rst while mem_wb valid → next cycle busy_mask=0 and rf_we=0. After reset is released, ld_issue to r2 is accepted immediately.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between load writeback and ALU writeback,
// with a per-register outstanding-load scoreboard driving decode hazard stalls.
module regfile_wb_arbiter #(
   parameter int unsigned NREGS          = 16,
   parameter int unsigned XLEN           = 16,
   parameter int unsigned MAX_MEM_STREAK = 3,
   localparam int unsigned IDX_W         = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_issue_valid,
   input  logic [IDX_W-1:0]  ld_issue_idx,
   output logic              ld_issue_ready,
   input  logic              mem_wb_valid,
   input  logic [IDX_W-1:0]  mem_wb_idx,
   input  logic [XLEN-1:0]   mem_wb_data,
   output logic              mem_wb_ready,
   input  logic              alu_wb_valid,
   input  logic [IDX_W-1:0]  alu_wb_idx,
   input  logic [XLEN-1:0]   alu_wb_data,
   output logic              alu_wb_ready,
   input  logic [IDX_W-1:0]  hz_rs1_i,
   input  logic [IDX_W-1:0]  hz_rs2_i,
   output logic              hz_stall,
   output logic              rf_we,
   output logic [IDX_W-1:0]  rf_idx,
   output logic [XLEN-1:0]   rf_data,
   output logic [NREGS-1:0]  busy_mask
);

   localparam int unsigned STREAK_W = $clog2(MAX_MEM_STREAK + 1);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  data;
   } wb_t;

   logic [NREGS-1:0]    busy_q, busy_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                alu_elig, alu_req, streak_max;
   logic                grant_mem, grant_alu, ld_accept;
   logic                hit1, hit2;
   wb_t                 win;

   // Grant selection: ALU is blocked while a load to its destination is pending
   always_comb begin
      alu_elig   = (alu_wb_idx == '0) || !busy_q[alu_wb_idx];
      alu_req    = alu_wb_valid && alu_elig;
      streak_max = (streak_q == STREAK_W'(MAX_MEM_STREAK));
      grant_mem  = mem_wb_valid && !(alu_req && streak_max);
      grant_alu  = alu_req && !grant_mem;
      win.idx    = grant_mem ? mem_wb_idx  : alu_wb_idx;
      win.data   = grant_mem ? mem_wb_data : alu_wb_data;
   end

   assign mem_wb_ready   = grant_mem;
   assign alu_wb_ready   = grant_alu;
   assign ld_issue_ready = !busy_q[ld_issue_idx] || (ld_issue_idx == '0);
   assign ld_accept      = ld_issue_valid && ld_issue_ready;

   // Scoreboard update: clear on load writeback, then set on issue
   always_comb begin
      busy_d = busy_q;
      if (grant_mem)
         busy_d[mem_wb_idx] = 1'b0;
      if (ld_accept)
         busy_d[ld_issue_idx] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      streak_d = streak_q;
      if (!alu_wb_valid || grant_alu)
         streak_d = '0;
      else if (grant_mem && alu_req && !streak_max)
         streak_d = streak_q + STREAK_W'(1);
   end

   // In-flight write term covers the cycle between scoreboard clear and RF commit
   assign hit1 = (hz_rs1_i != '0) && (busy_q[hz_rs1_i] || (rf_we && (rf_idx == hz_rs1_i)));
   assign hit2 = (hz_rs2_i != '0) && (busy_q[hz_rs2_i] || (rf_we && (rf_idx == hz_rs2_i)));
   assign hz_stall  = hit1 || hit2;
   assign busy_mask = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= '0;
         streak_q <= '0;
         rf_we    <= 1'b0;
         rf_idx   <= '0;
         rf_data  <= '0;
      end else begin
         busy_q   <= busy_d;
         streak_q <= streak_d;
         rf_we    <= (grant_mem || grant_alu) && (win.idx != '0);
         if (grant_mem || grant_alu) begin
            rf_idx  <= win.idx;
            rf_data <= win.data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; register-file writes are checked
// in order against a queue of expected {idx,data} pairs.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_issue_valid;
   logic [3:0]  ld_issue_idx;
   logic        ld_issue_ready;
   logic        mem_wb_valid;
   logic [3:0]  mem_wb_idx;
   logic [15:0] mem_wb_data;
   logic        mem_wb_ready;
   logic        alu_wb_valid;
   logic [3:0]  alu_wb_idx;
   logic [15:0] alu_wb_data;
   logic        alu_wb_ready;
   logic [3:0]  hz_rs1_i;
   logic [3:0]  hz_rs2_i;
   logic        hz_stall;
   logic        rf_we;
   logic [3:0]  rf_idx;
   logic [15:0] rf_data;
   logic [15:0] busy_mask;

   int n_vec = 0;
   int n_err = 0;
   logic [19:0] exp_q[$];

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .ld_issue_valid(ld_issue_valid), .ld_issue_idx(ld_issue_idx), .ld_issue_ready(ld_issue_ready),
      .mem_wb_valid(mem_wb_valid), .mem_wb_idx(mem_wb_idx), .mem_wb_data(mem_wb_data),
      .mem_wb_ready(mem_wb_ready),
      .alu_wb_valid(alu_wb_valid), .alu_wb_idx(alu_wb_idx), .alu_wb_data(alu_wb_data),
      .alu_wb_ready(alu_wb_ready),
      .hz_rs1_i(hz_rs1_i), .hz_rs2_i(hz_rs2_i), .hz_stall(hz_stall),
      .rf_we(rf_we), .rf_idx(rf_idx), .rf_data(rf_data), .busy_mask(busy_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every RF write must match the next expected entry
   always @(negedge clk) begin
      if (rf_we) begin
         if (exp_q.size() == 0) begin
            check("rf_unexpected_write", 32'(rf_idx), 32'hDEAD);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("rf_idx", 32'(rf_idx), 32'(e[19:16]));
            check("rf_data", 32'(rf_data), 32'(e[15:0]));
         end
      end
   end

   localparam string GRANTS = "mmmamm";

   initial begin
      logic [15:0] md, ad;
      rst = 1'b1;
      ld_issue_valid = 0; ld_issue_idx = 0;
      mem_wb_valid = 0; mem_wb_idx = 0; mem_wb_data = 0;
      alu_wb_valid = 0; alu_wb_idx = 0; alu_wb_data = 0;
      hz_rs1_i = 0; hz_rs2_i = 0;
      tick(); tick();
      check("rst_rf_we", 32'(rf_we), 0);
      check("rst_rf_idx", 32'(rf_idx), 0);
      check("rst_rf_data", 32'(rf_data), 0);
      check("rst_busy", 32'(busy_mask), 0);
      rst = 1'b0;

      // ALU write alone
      alu_wb_valid = 1; alu_wb_idx = 3; alu_wb_data = 16'h1234;
      #1;
      check("s1_alu_ready", 32'(alu_wb_ready), 1);
      check("s1_mem_ready", 32'(mem_wb_ready), 0);
      exp_q.push_back({4'd3, 16'h1234});
      tick();
      alu_wb_valid = 0;
      check("s1_rf_we", 32'(rf_we), 1);
      check("s1_rf_idx", 32'(rf_idx), 3);
      check("s1_rf_data", 32'(rf_data), 32'h1234);
      tick();
      check("s1_rf_we_off", 32'(rf_we), 0);

      // Load to r5 and RAW stall through writeback
      ld_issue_valid = 1; ld_issue_idx = 5;
      #1;
      check("s2_ld_ready", 32'(ld_issue_ready), 1);
      tick();
      ld_issue_valid = 0; hz_rs1_i = 5;
      #1;
      check("s2_busy", 32'(busy_mask), 32'h0020);
      check("s2_stall_busy", 32'(hz_stall), 1);
      mem_wb_valid = 1; mem_wb_idx = 5; mem_wb_data = 16'hBEEF;
      #1;
      check("s2_mem_ready", 32'(mem_wb_ready), 1);
      exp_q.push_back({4'd5, 16'hBEEF});
      tick();
      mem_wb_valid = 0;
      #1;
      check("s2_busy_clr", 32'(busy_mask), 0);
      check("s2_stall_inflight", 32'(hz_stall), 1);
      tick();
      check("s2_stall_done", 32'(hz_stall), 0);
      hz_rs1_i = 0;

      // Contention: memory streak then forced ALU grant
      md = 16'h1000; ad = 16'hA000;
      mem_wb_valid = 1; mem_wb_idx = 1;
      alu_wb_valid = 1; alu_wb_idx = 4;
      for (int k = 0; k < 6; k++) begin
         mem_wb_data = md; alu_wb_data = ad;
         #1;
         if (GRANTS[k] == "m") begin
            check($sformatf("s3_mem_ready%0d", k), 32'(mem_wb_ready), 1);
            check($sformatf("s3_alu_ready%0d", k), 32'(alu_wb_ready), 0);
            exp_q.push_back({4'd1, md});
            md = md + 16'd1;
         end else begin
            check($sformatf("s3_mem_ready%0d", k), 32'(mem_wb_ready), 0);
            check($sformatf("s3_alu_ready%0d", k), 32'(alu_wb_ready), 1);
            exp_q.push_back({4'd4, ad});
            ad = ad + 16'd1;
         end
         tick();
      end
      mem_wb_valid = 0; alu_wb_valid = 0;
      tick();

      // ALU WAW against outstanding load to r7
      ld_issue_valid = 1; ld_issue_idx = 7;
      tick();
      ld_issue_valid = 0;
      alu_wb_valid = 1; alu_wb_idx = 7; alu_wb_data = 16'h7A7A;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("s4_alu_blocked%0d", k), 32'(alu_wb_ready), 0);
         tick();
      end
      mem_wb_valid = 1; mem_wb_idx = 7; mem_wb_data = 16'h7777;
      #1;
      check("s4_mem_ready", 32'(mem_wb_ready), 1);
      check("s4_alu_still_blocked", 32'(alu_wb_ready), 0);
      exp_q.push_back({4'd7, 16'h7777});
      tick();
      mem_wb_valid = 0;
      #1;
      check("s4_alu_ready", 32'(alu_wb_ready), 1);
      exp_q.push_back({4'd7, 16'h7A7A});
      tick();
      alu_wb_valid = 0;
      check("s4_final_data", 32'(rf_data), 32'h7A7A);
      tick();

      // r0 is never written and never marked busy
      alu_wb_valid = 1; alu_wb_idx = 0; alu_wb_data = 16'hFFFF;
      #1;
      check("s5_alu_r0_ready", 32'(alu_wb_ready), 1);
      tick();
      alu_wb_valid = 0;
      check("s5_rf_we_r0", 32'(rf_we), 0);
      check("s5_rf_idx_r0", 32'(rf_idx), 0);
      ld_issue_valid = 1; ld_issue_idx = 0;
      #1;
      check("s5_ld_r0_ready", 32'(ld_issue_ready), 1);
      tick();
      ld_issue_valid = 0;
      check("s5_busy_r0", 32'(busy_mask), 0);

      // Reset while a load is outstanding and its writeback is presented
      ld_issue_valid = 1; ld_issue_idx = 2;
      tick();
      ld_issue_valid = 0;
      check("s6_busy_r2", 32'(busy_mask), 32'h0004);
      #1;
      check("s6_ld_r2_blocked", 32'(ld_issue_ready), 0);
      rst = 1; mem_wb_valid = 1; mem_wb_idx = 2; mem_wb_data = 16'h2222;
      tick();
      rst = 0; mem_wb_valid = 0;
      check("s6_busy_after_rst", 32'(busy_mask), 0);
      check("s6_rf_we_after_rst", 32'(rf_we), 0);
      ld_issue_valid = 1; ld_issue_idx = 2;
      #1;
      check("s6_ld_r2_ready", 32'(ld_issue_ready), 1);
      tick();
      ld_issue_valid = 0;
      check("s6_busy_r2_again", 32'(busy_mask), 32'h0004);

      // Same-cycle writeback and re-issue to a busy register
      mem_wb_valid = 1; mem_wb_idx = 2; mem_wb_data = 16'h2B2B;
      ld_issue_valid = 1; ld_issue_idx = 2;
      #1;
      check("s7_ld_blocked", 32'(ld_issue_ready), 0);
      check("s7_mem_ready", 32'(mem_wb_ready), 1);
      exp_q.push_back({4'd2, 16'h2B2B});
      tick();
      mem_wb_valid = 0;
      check("s7_busy_clr", 32'(busy_mask), 0);
      #1;
      check("s7_ld_ready", 32'(ld_issue_ready), 1);
      tick();
      ld_issue_valid = 0;
      check("s7_busy_set", 32'(busy_mask), 32'h0004);
      tick(); tick();

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
